// File: rtl/branch_rs_pkg.sv
// Shared opcodes, funct3 codes and entry layout for the branch reservation station.
// BRANCH_RS_PREDICT_EN adds per-entry prediction fields.
package branch_rs_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Entry fields are sized for the widest supported build; stations use the low bits.
    localparam int XLEN_MAX  = 64;
    localparam int ROB_W_MAX = 16;
    localparam int AGE_W_MAX = 8;

    function automatic int age_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic                 pending;
        logic [ROB_W_MAX-1:0] tag;
        logic [XLEN_MAX-1:0]  data;
    } operand_t;

    typedef struct packed {
        logic                 busy;
        logic [ROB_W_MAX-1:0] rob;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [XLEN_MAX-1:0]  pc;
        logic [XLEN_MAX-1:0]  imm;
        operand_t             src1;
        operand_t             src2;
`ifdef BRANCH_RS_PREDICT_EN
        logic                 pred_taken;
        logic [XLEN_MAX-1:0]  pred_target;
`endif
        logic [AGE_W_MAX-1:0] age;
    } entry_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolver: condition, next PC and link value.
module branch_resolve
    import branch_rs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (src1 == src2);
            F3_BNE:  cond = (src1 != src2);
            F3_BLT:  cond = ($signed(src1) <  $signed(src2));
            F3_BGE:  cond = ($signed(src1) >= $signed(src2));
            F3_BLTU: cond = (src1 <  src2);
            F3_BGEU: cond = (src1 >= src2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        link   = pc + XLEN'(4);
        taken  = 1'b0;
        target = link;
        if (opcode == OP_JAL) begin
            taken  = 1'b1;
            target = pc + imm;
        end else if (opcode == OP_JALR) begin
            taken  = 1'b1;
            target = (src1 + imm) & ~XLEN'(1);
        end else begin
            taken  = cond;
            target = cond ? (pc + imm) : link;
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch/jump reservation station: CDB wakeup, oldest-ready issue, in-slot resolution.
// Optional prediction check enabled by BRANCH_RS_PREDICT_EN.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CDB_PORTS = 2,
    parameter int XLEN      = 32,
    parameter int ROB_W     = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          dispatch_valid,
    output logic                          dispatch_ready,
    input  logic [6:0]                    dispatch_opcode,
    input  logic [2:0]                    dispatch_funct3,
    input  logic [XLEN-1:0]               dispatch_pc,
    input  logic [XLEN-1:0]               dispatch_imm,
    input  logic [ROB_W-1:0]              dispatch_rob,
    input  logic [XLEN-1:0]               dispatch_src1_data,
    input  logic                          dispatch_src1_pending,
    input  logic [ROB_W-1:0]              dispatch_src1_tag,
    input  logic [XLEN-1:0]               dispatch_src2_data,
    input  logic                          dispatch_src2_pending,
    input  logic [ROB_W-1:0]              dispatch_src2_tag,
`ifdef BRANCH_RS_PREDICT_EN
    input  logic                          dispatch_pred_taken,
    input  logic [XLEN-1:0]               dispatch_pred_target,
`endif
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]     cdb_data,
    output logic                          result_valid,
    output logic [ROB_W-1:0]              result_rob,
    output logic [XLEN-1:0]               result_target,
    output logic [XLEN-1:0]               result_link,
    output logic                          result_taken,
    output logic                          result_mispredict,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int AGE_W = age_width(DEPTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    entry_t            ent [DEPTH];
    entry_t            new_ent;
    logic [XLEN:0]     wake1 [DEPTH];
    logic [XLEN:0]     wake2 [DEPTH];
    logic [XLEN:0]     byp1, byp2;
    logic              s1_pend, s2_pend;
    logic              has_free, issue, accept;
    logic [IDX_W-1:0]  free_idx, sel;
    logic [AGE_W-1:0]  sel_age;
    int unsigned       busy_cnt;
    logic              res_taken;
    logic [XLEN-1:0]   res_target, res_link;

    // {hit, data} for a tag on the CDB; the lowest matching port wins.
    function automatic logic [XLEN:0] snoop(input logic [ROB_W-1:0] tag);
        logic [XLEN:0] r;
        r = '0;
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            if (!r[XLEN] && cdb_valid[p] && (cdb_tag[p*ROB_W +: ROB_W] == tag))
                r = {1'b1, cdb_data[p*XLEN +: XLEN]};
        end
        return r;
    endfunction

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        issue    = 1'b0;
        sel      = '0;
        sel_age  = '0;
        busy_cnt = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wake1[i] = snoop(ent[i].src1.tag[ROB_W-1:0]);
            wake2[i] = snoop(ent[i].src2.tag[ROB_W-1:0]);
            if (ent[i].busy)
                busy_cnt = busy_cnt + 1;
            else if (!has_free) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ent[i].busy && !ent[i].src1.pending && !ent[i].src2.pending &&
                (!issue || ent[i].age[AGE_W-1:0] < sel_age)) begin
                issue   = 1'b1;
                sel     = IDX_W'(i);
                sel_age = ent[i].age[AGE_W-1:0];
            end
        end
    end

    assign occupancy      = OCC_W'(busy_cnt);
    assign dispatch_ready = has_free && !reset;
    assign accept         = dispatch_valid && dispatch_ready;

    always_comb begin
        s1_pend = dispatch_src1_pending && (dispatch_opcode != OP_JAL);
        s2_pend = dispatch_src2_pending && (dispatch_opcode != OP_JAL) && (dispatch_opcode != OP_JALR);
        byp1    = snoop(dispatch_src1_tag);
        byp2    = snoop(dispatch_src2_tag);
        new_ent              = '0;
        new_ent.busy         = 1'b1;
        new_ent.rob          = ROB_W_MAX'(dispatch_rob);
        new_ent.opcode       = dispatch_opcode;
        new_ent.funct3       = dispatch_funct3;
        new_ent.pc           = XLEN_MAX'(dispatch_pc);
        new_ent.imm          = XLEN_MAX'(dispatch_imm);
        new_ent.src1.pending = s1_pend && !byp1[XLEN];
        new_ent.src1.tag     = ROB_W_MAX'(dispatch_src1_tag);
        new_ent.src1.data    = XLEN_MAX'((s1_pend && byp1[XLEN]) ? byp1[XLEN-1:0] : dispatch_src1_data);
        new_ent.src2.pending = s2_pend && !byp2[XLEN];
        new_ent.src2.tag     = ROB_W_MAX'(dispatch_src2_tag);
        new_ent.src2.data    = XLEN_MAX'((s2_pend && byp2[XLEN]) ? byp2[XLEN-1:0] : dispatch_src2_data);
`ifdef BRANCH_RS_PREDICT_EN
        new_ent.pred_taken   = dispatch_pred_taken;
        new_ent.pred_target  = XLEN_MAX'(dispatch_pred_target);
`endif
        // Ages stay a dense 0..n-1 rank; the newcomer lands after any entry leaving this edge.
        new_ent.age          = AGE_W_MAX'(busy_cnt - (issue ? 32'd1 : 32'd0));
    end

    branch_resolve #(.XLEN(XLEN)) u_resolve (
        .opcode (ent[sel].opcode),
        .funct3 (ent[sel].funct3),
        .src1   (ent[sel].src1.data[XLEN-1:0]),
        .src2   (ent[sel].src2.data[XLEN-1:0]),
        .pc     (ent[sel].pc[XLEN-1:0]),
        .imm    (ent[sel].imm[XLEN-1:0]),
        .taken  (res_taken),
        .target (res_target),
        .link   (res_link)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
            result_valid  <= 1'b0;
            result_rob    <= '0;
            result_target <= '0;
            result_link   <= '0;
            result_taken  <= 1'b0;
`ifdef BRANCH_RS_PREDICT_EN
            result_mispredict <= 1'b0;
`endif
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= issue;
            if (issue) begin
                result_rob    <= ent[sel].rob[ROB_W-1:0];
                result_target <= res_target;
                result_link   <= res_link;
                result_taken  <= res_taken;
`ifdef BRANCH_RS_PREDICT_EN
                result_mispredict <= (res_taken != ent[sel].pred_taken) ||
                                     (res_taken && (res_target != ent[sel].pred_target[XLEN-1:0]));
`endif
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent[i].busy) begin
                    if (ent[i].src1.pending && wake1[i][XLEN]) begin
                        ent[i].src1.pending <= 1'b0;
                        ent[i].src1.data    <= XLEN_MAX'(wake1[i][XLEN-1:0]);
                    end
                    if (ent[i].src2.pending && wake2[i][XLEN]) begin
                        ent[i].src2.pending <= 1'b0;
                        ent[i].src2.data    <= XLEN_MAX'(wake2[i][XLEN-1:0]);
                    end
                    if (issue && ent[i].age[AGE_W-1:0] > sel_age)
                        ent[i].age <= ent[i].age - AGE_W_MAX'(1);
                    if (issue && IDX_W'(i) == sel)
                        ent[i].busy <= 1'b0;
                end
            end
            if (accept)
                ent[free_idx] <= new_ent;
        end
    end

`ifndef BRANCH_RS_PREDICT_EN
    assign result_mispredict = 1'b0;
`endif

endmodule

// File: tb/tb_branch_rs.sv
// Randomised and directed bench for branch_rs against an in-order queue model.
// Prediction ports are exercised when BRANCH_RS_PREDICT_EN is defined.
module tb_branch_rs;

    localparam int DEPTH     = 4;
    localparam int CDB_PORTS = 2;
    localparam int XLEN      = 32;
    localparam int ROB_W     = 6;
    localparam logic [6:0] OPB = 7'b1100011;
    localparam logic [6:0] OPJ = 7'b1101111;
    localparam logic [6:0] OPR = 7'b1100111;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                       reset, flush, dispatch_valid, dispatch_ready;
    logic [6:0]                 dispatch_opcode;
    logic [2:0]                 dispatch_funct3;
    logic [XLEN-1:0]            dispatch_pc, dispatch_imm, dispatch_src1_data, dispatch_src2_data;
    logic [ROB_W-1:0]           dispatch_rob, dispatch_src1_tag, dispatch_src2_tag;
    logic                       dispatch_src1_pending, dispatch_src2_pending;
    logic                       dispatch_pred_taken;
    logic [XLEN-1:0]            dispatch_pred_target;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*ROB_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0]  cdb_data;
    logic                       result_valid, result_taken, result_mispredict;
    logic [ROB_W-1:0]           result_rob;
    logic [XLEN-1:0]            result_target, result_link;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    branch_rs #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS), .XLEN(XLEN), .ROB_W(ROB_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_opcode(dispatch_opcode), .dispatch_funct3(dispatch_funct3),
        .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm), .dispatch_rob(dispatch_rob),
        .dispatch_src1_data(dispatch_src1_data), .dispatch_src1_pending(dispatch_src1_pending),
        .dispatch_src1_tag(dispatch_src1_tag),
        .dispatch_src2_data(dispatch_src2_data), .dispatch_src2_pending(dispatch_src2_pending),
        .dispatch_src2_tag(dispatch_src2_tag),
`ifdef BRANCH_RS_PREDICT_EN
        .dispatch_pred_taken(dispatch_pred_taken), .dispatch_pred_target(dispatch_pred_target),
`endif
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .result_valid(result_valid), .result_rob(result_rob), .result_target(result_target),
        .result_link(result_link), .result_taken(result_taken),
        .result_mispredict(result_mispredict), .occupancy(occupancy)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc, imm, d1, d2, ptgt;
        logic [5:0]  rob, t1, t2;
        logic        p1, p2, pt;
    } mop_t;

    mop_t        q[$];
    logic        exp_valid, exp_taken, exp_mis;
    logic [5:0]  exp_rob;
    logic [31:0] exp_target, exp_link;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] msnoop(input logic [5:0] tag);
        for (int p = 0; p < CDB_PORTS; p++)
            if (cdb_valid[p] && cdb_tag[p*ROB_W +: ROB_W] == tag)
                return {1'b1, cdb_data[p*XLEN +: XLEN]};
        return 33'd0;
    endfunction

    function automatic void mresolve(input mop_t m, output logic tk, output logic [31:0] tg);
        if (m.op == OPJ) begin
            tk = 1'b1; tg = m.pc + m.imm;
        end else if (m.op == OPR) begin
            tk = 1'b1; tg = (m.d1 + m.imm) & 32'hFFFF_FFFE;
        end else begin
            case (m.f3)
                3'd0: tk = (m.d1 == m.d2);
                3'd1: tk = (m.d1 != m.d2);
                3'd4: tk = ($signed(m.d1) <  $signed(m.d2));
                3'd5: tk = ($signed(m.d1) >= $signed(m.d2));
                3'd6: tk = (m.d1 <  m.d2);
                3'd7: tk = (m.d1 >= m.d2);
                default: tk = 1'b0;
            endcase
            tg = tk ? m.pc + m.imm : m.pc + 32'd4;
        end
    endfunction

    // One clock: predict from the model, advance, then compare every output.
    task automatic step();
        mop_t m;
        logic tk, acc;
        logic [31:0] tg;
        logic [32:0] s;
        int idx;
        #1;
        chk("dispatch_ready", dispatch_ready, (!reset && q.size() < DEPTH));
        if (reset) begin
            q.delete();
            exp_valid = 0; exp_rob = 0; exp_target = 0; exp_link = 0; exp_taken = 0; exp_mis = 0;
        end else if (flush) begin
            q.delete();
            exp_valid = 0;
        end else begin
            idx = -1;
            foreach (q[i]) if (idx < 0 && !q[i].p1 && !q[i].p2) idx = i;
            exp_valid = (idx >= 0);
            if (idx >= 0) begin
                mresolve(q[idx], tk, tg);
                exp_rob = q[idx].rob; exp_taken = tk; exp_target = tg; exp_link = q[idx].pc + 32'd4;
`ifdef BRANCH_RS_PREDICT_EN
                exp_mis = (tk != q[idx].pt) || (tk && tg != q[idx].ptgt);
`else
                exp_mis = 1'b0;
`endif
            end
            acc = dispatch_valid && q.size() < DEPTH;
            if (idx >= 0) q.delete(idx);
            foreach (q[i]) begin
                if (q[i].p1) begin s = msnoop(q[i].t1); if (s[32]) begin q[i].p1 = 0; q[i].d1 = s[31:0]; end end
                if (q[i].p2) begin s = msnoop(q[i].t2); if (s[32]) begin q[i].p2 = 0; q[i].d2 = s[31:0]; end end
            end
            if (acc) begin
                m.op = dispatch_opcode; m.f3 = dispatch_funct3; m.pc = dispatch_pc; m.imm = dispatch_imm;
                m.rob = dispatch_rob; m.t1 = dispatch_src1_tag; m.t2 = dispatch_src2_tag;
                m.d1 = dispatch_src1_data; m.d2 = dispatch_src2_data;
                m.pt = dispatch_pred_taken; m.ptgt = dispatch_pred_target;
                m.p1 = dispatch_src1_pending && m.op != OPJ;
                m.p2 = dispatch_src2_pending && m.op == OPB;
                if (m.p1) begin s = msnoop(m.t1); if (s[32]) begin m.p1 = 0; m.d1 = s[31:0]; end end
                if (m.p2) begin s = msnoop(m.t2); if (s[32]) begin m.p2 = 0; m.d2 = s[31:0]; end end
                q.push_back(m);
            end
        end
        @(posedge clock);
        #1;
        chk("result_valid", result_valid, exp_valid);
        chk("result_rob", result_rob, exp_rob);
        chk("result_target", result_target, exp_target);
        chk("result_link", result_link, exp_link);
        chk("result_taken", result_taken, exp_taken);
        chk("result_mispredict", result_mispredict, exp_mis);
        chk("occupancy", occupancy, q.size());
    endtask

    task automatic idle();
        reset = 0; flush = 0; dispatch_valid = 0; cdb_valid = '0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [5:0] rob, input logic p1, input logic [5:0] t1, input logic [31:0] d1,
                        input logic p2, input logic [5:0] t2, input logic [31:0] d2);
        dispatch_valid = 1; dispatch_opcode = op; dispatch_funct3 = f3; dispatch_pc = pc; dispatch_imm = imm;
        dispatch_rob = rob; dispatch_src1_pending = p1; dispatch_src1_tag = t1; dispatch_src1_data = d1;
        dispatch_src2_pending = p2; dispatch_src2_tag = t2; dispatch_src2_data = d2;
    endtask

    task automatic bcast(input int p, input logic [5:0] tag, input logic [31:0] data);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*ROB_W +: ROB_W] = tag;
        cdb_data[p*XLEN +: XLEN] = data;
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'd5;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle();
        cdb_tag = '0; cdb_data = '0;
        dispatch_pred_taken = 0; dispatch_pred_target = '0;
        disp(OPB, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dispatch_valid = 0;

        reset = 1;
        step();
        #1 chk("ready_in_reset", dispatch_ready, 0);
        step();
        idle();
        chk("reset_occ", occupancy, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_target", result_target, 0);

        // ready BEQ
        disp(OPB, 3'd0, 32'h100, 32'h20, 6'd9, 0, 0, 32'd5, 0, 0, 32'd5);
        step(); idle(); step();
        chk("beq_valid", result_valid, 1);
        chk("beq_taken", result_taken, 1);
        chk("beq_target", result_target, 32'h120);
        chk("beq_link", result_link, 32'h104);

        // BLT then BLTU woken by CDB port 1
        for (int k = 0; k < 2; k++) begin
            disp(OPB, (k == 0) ? 3'd4 : 3'd6, 32'h200, 32'h40, 6'd11, 1, 6'd3, 0, 0, 0, 0);
            step(); idle();
            bcast(1, 6'd3, 32'hFFFF_FFFF);
            step(); idle();
            chk("wake_not_yet", result_valid, 0);
            step();
            chk("wake_taken", result_taken, (k == 0) ? 1 : 0);
            chk("wake_target", result_target, (k == 0) ? 32'h240 : 32'h204);
        end

        // fill, full, release in age order
        for (int i = 0; i < DEPTH; i++) begin
            disp(OPB, 3'd1, 32'h300 + 32'(i * 16), 32'h10, 6'(20 + i), 1, 6'd7, 0, 0, 0, 32'd1);
            step();
        end
        #1 chk("full_ready", dispatch_ready, 0);
        chk("full_occ", occupancy, DEPTH);
        disp(OPB, 3'd1, 32'h3F0, 32'h10, 6'd30, 0, 0, 0, 0, 0, 32'd1);
        step(); idle();
        bcast(0, 6'd7, 32'd0);
        step(); idle();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("fill_order", result_rob, 20 + i);
        end
        chk("drain_occ", occupancy, 0);

        // dual-port wakeup with a bypassed dispatch in the same cycle
        disp(OPB, 3'd0, 32'h400, 32'h8, 6'd40, 1, 6'd1, 0, 0, 0, 32'hAA); step();
        disp(OPB, 3'd0, 32'h500, 32'h8, 6'd41, 1, 6'd2, 0, 0, 0, 32'hBB); step();
        disp(OPB, 3'd0, 32'h600, 32'h8, 6'd42, 1, 6'd1, 0, 0, 0, 32'hAA);
        bcast(0, 6'd1, 32'hAA); bcast(1, 6'd2, 32'hBB);
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dual_rob", result_rob, 40 + i);
            chk("dual_taken", result_taken, 1);
        end

        // flush with a ready entry and a same-cycle dispatch
        disp(OPB, 3'd0, 32'h700, 0, 6'd50, 0, 0, 1, 0, 0, 1); step();
        disp(OPB, 3'd0, 32'h710, 0, 6'd51, 0, 0, 1, 0, 0, 1); flush = 1;
        step(); idle();
        #1;
        chk("flush_valid", result_valid, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_ready", dispatch_ready, 1);

        // JALR clears bit 0 and ignores src2
        disp(OPR, 3'd0, 32'h800, 32'd4, 6'd52, 0, 0, 32'h1003, 1, 6'd5, 0);
        dispatch_pred_taken = 1; dispatch_pred_target = 32'h1000;
        step(); idle(); step();
        chk("jalr_target", result_target, 32'h1006);
        chk("jalr_link", result_link, 32'h804);
        chk("jalr_taken", result_taken, 1);
`ifdef BRANCH_RS_PREDICT_EN
        chk("jalr_mispredict", result_mispredict, 1);
`endif

        for (int c = 0; c < 3000; c++) begin
            idle();
            reset = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0) begin
                int k;
                k = $urandom_range(0, 9);
                disp((k < 7) ? OPB : (k < 9) ? OPJ : OPR, 3'($urandom_range(0, 7)),
                     $urandom & 32'hFFFF_FFFC, rnd_data(), 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), rnd_data(),
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), rnd_data());
                dispatch_pred_taken  = 1'($urandom_range(0, 1));
                dispatch_pred_target = $urandom_range(0, 1) ? dispatch_pc + dispatch_imm : $urandom;
            end
            for (int p = 0; p < CDB_PORTS; p++)
                if ($urandom_range(0, 2) == 0) bcast(p, 6'($urandom_range(0, 7)), rnd_data());
            step();
        end
        idle();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
